apb_response_arbiter: RTL

Parametrised APB completer-side response arbiter for N slaves sharing one APB requester port. It routes the selected slave's PREADY/PRDATA/PSLVERR back to the bridge, tracks APB phases with a small state machine, and rejects protocol and select errors with PSLVERR. It bounds stalled transfers with a wait-state timeout and keeps a saturating error count. It sits between the APB decoder and the bridge, replacing the fixed two-slave, write/read-only response mux.

---
 rtl/apb_response_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/apb_response_arbiter.sv
// APB completer-side response arbiter: muxes one of SEL_WIDTH slave responses back to the bridge,
// flags protocol/select errors and counts error completions. Optional timeout: `define APB_ARB_TIMEOUT_EN.
module apb_response_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                            i_PCLK,
  input  logic                            i_PRESET,
  input  logic [SEL_WIDTH-1:0]            i_PSEL,
  input  logic                            i_PENABLE,
  input  logic                            i_PWRITE,
  input  logic [SEL_WIDTH-1:0]            i_PREADY,
  input  logic [SEL_WIDTH-1:0]            i_PSLVERR,
  input  logic [DATA_WIDTH*SEL_WIDTH-1:0] i_PRDATA,
  input  logic                            i_ERR_CLR,
  output logic                            o_PREADY,
  output logic [DATA_WIDTH-1:0]           o_PRDATA,
  output logic                            o_PSLVERR,
  output logic [SEL_WIDTH-1:0]            o_ABORT,
  output logic [ERR_CNT_WIDTH-1:0]        o_ERR_COUNT
);

  localparam int IDX_W = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                   state;
  logic                     sel_any;
  logic                     sel_valid;
  logic [IDX_W-1:0]         sel_idx;
  logic [DATA_WIDTH-1:0]    slv_rdata;
  logic                     rsp_ready;
  logic                     rsp_err;
  logic [DATA_WIDTH-1:0]    rsp_data;
  logic [SEL_WIDTH-1:0]     rsp_abort;
  logic                     done;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              timed_out;
  assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // select decode: x & (x-1) clears the lowest set bit, so zero means at most one bit set
  always_comb begin
    sel_any   = |i_PSEL;
    sel_valid = sel_any && ((i_PSEL & (i_PSEL - SEL_WIDTH'(1))) == '0);
    sel_idx   = '0;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (i_PSEL[i]) sel_idx = IDX_W'(i);
    end
    slv_rdata = i_PRDATA[sel_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  // combinational response path; everything stays 0 while reset is held
  always_comb begin
    rsp_ready = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    rsp_abort = '0;
    if (!i_PRESET) begin
      if (state == IDLE) begin
        if (sel_any && i_PENABLE) begin
          rsp_ready = 1'b1;
          rsp_err   = 1'b1;
        end
      end else if (sel_valid) begin
        if (i_PREADY[sel_idx]) begin
          rsp_ready = 1'b1;
          rsp_err   = i_PSLVERR[sel_idx];
          if (!i_PWRITE) rsp_data = slv_rdata;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (timed_out) begin
          rsp_ready          = 1'b1;
          rsp_err            = 1'b1;
          rsp_abort[sel_idx] = 1'b1;
        end
`endif
      end else if (sel_any) begin
        rsp_ready = 1'b1;
        rsp_err   = 1'b1;
      end
    end
  end

  assign done = i_PENABLE & rsp_ready;

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      state <= IDLE;
`ifdef APB_ARB_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sel_any && !i_PENABLE) begin
            state <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        ACCESS: begin
          if (!sel_any) begin
            state <= IDLE;
          end else begin
`ifdef APB_ARB_TIMEOUT_EN
            if (!rsp_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
`endif
            if (done) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // saturating error count; clear wins over a same-cycle increment
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET || i_ERR_CLR) begin
      err_cnt <= '0;
    end else if (done && rsp_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  assign o_PREADY    = rsp_ready;
  assign o_PSLVERR   = rsp_err;
  assign o_PRDATA    = rsp_data;
  assign o_ABORT     = rsp_abort;
  assign o_ERR_COUNT = err_cnt;

endmodule
